btn_step_pulse_gen: RTL and testbench
=====================================

# btn_step_pulse_gen

Front-end stage that turns two raw push-buttons (up, down) into the one-cycle `pulse` strobe and the `cnt_up` direction level consumed by the downstream stepping state machine. It synchronizes and debounces each button and emits exactly one pulse per accepted press. It also holds the direction of the most recent accepted press. An optional auto-repeat mode emits further pulses while a button is held.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a level change (≥2).
- `HOLD_CYCLES`, default 50_000_000: cycles from the press pulse to the first repeat pulse (auto-repeat only).
- `REPEAT_CYCLES`, default 20_000_000: cycles between repeat pulses (auto-repeat only).
- `clk` in 1: single clock; all state on its rising edge.
- `reset` in 1: synchronous, active-low; asserted when 0, sampled on the rising edge of `clk`.
- `btn_up` in 1: raw asynchronous up button, active-high.
- `btn_dn` in 1: raw asynchronous down button, active-high.
- `pulse` out 1: registered one-cycle step strobe.
- `cnt_up` out 1: registered direction; 1 = up, 0 = down; valid whenever `pulse` = 1.
- `up_level` out 1: debounced up-button level.
- `dn_level` out 1: debounced down-button level.

## Operation
- Reset (`reset` = 0 at an edge): all synchronizers, debounced levels, counters and FSM state clear. Outputs: `pulse` = 0, `cnt_up` = 1, `up_level` = 0, `dn_level` = 0.
- Synchronizer: two flops per button, reset to 0.
- Debounce, per button: sample s, level d. The counter clears whenever s == d and increments while s != d. When s != d and the counter = DEBOUNCE_CYCLES-1, d <= s and the counter clears. Counter width is `$clog2(DEBOUNCE_CYCLES)`; it never wraps.
- Press acceptance: a rising edge of one debounced level while the other level is 0 is an accepted press.
  - On acceptance, `pulse` = 1 the next cycle, with `cnt_up` = 1 for up and 0 for down.
  - `cnt_up` changes only in a cycle where `pulse` = 1; otherwise it holds.
- Simultaneous events:
  - Both levels rising in the same cycle: no pulse, `cnt_up` holds.
  - One level rising while the other is already 1: no pulse.
  - Falling edges never pulse.
- Auto-repeat FSM (macro only), states IDLE / HOLD / REPEAT, with a timer that clears on every transition:
  - IDLE → HOLD on an accepted press.
  - HOLD → IDLE if the pressed level falls or the other level rises.
  - HOLD → REPEAT when timer = HOLD_CYCLES-1; this emits a pulse with the same `cnt_up`.
  - REPEAT → IDLE on release or when the other button rises.
  - In REPEAT, timer = REPEAT_CYCLES-1 emits a pulse, clears the timer, and stays in REPEAT.
  - Timer width is sized for the larger of HOLD_CYCLES and REPEAT_CYCLES.

## Timing
- Raw edge to `up_level`/`dn_level` change: 2 + DEBOUNCE_CYCLES cycles, given a stable input.
- Debounced rising edge to `pulse`: 1 cycle. Raw press to `pulse` = 3 + DEBOUNCE_CYCLES cycles.
- `pulse` is high for exactly 1 cycle and never high on consecutive cycles.
- Repeat: the first repeat pulse comes HOLD_CYCLES cycles after the press pulse; later repeat pulses follow every REPEAT_CYCLES cycles.
- Glitches shorter than DEBOUNCE_CYCLES sampled cycles cause no level change and no pulse.
- Reset mid-operation takes effect at the next edge: any in-flight pulse is cancelled and the FSM returns to IDLE.
- A button held across reset release counts as a new press: one pulse follows 3 + DEBOUNCE_CYCLES cycles after release.

## Configuration
- `STEP_AUTOREPEAT_EN` defined: the auto-repeat FSM and timer are compiled in and behave as above.
- `STEP_AUTOREPEAT_EN` undefined: no FSM or timer logic exists; exactly one pulse per accepted press; HOLD_CYCLES and REPEAT_CYCLES are ignored.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 10, REPEAT_CYCLES = 5.
- Reset with reset = 0 for 3 cycles → `pulse` 0, `cnt_up` 1, both levels 0; after release with buttons low, no pulse for 50 cycles.
- Press and hold `btn_up` at cycle 0 (macro off) → `up_level` rises at cycle 6, single `pulse` at cycle 7 with `cnt_up` = 1, no further pulses.
- Bounce `btn_dn` 1-0-1 at 2-cycle intervals, then hold → exactly one `pulse`, `cnt_up` = 0, occurring 7 cycles after the last raw edge.
- Assert `btn_up` and `btn_dn` on the same cycle and hold → both levels go 1, no `pulse`, `cnt_up` unchanged.
- Macro on, hold `btn_up` for 40 cycles after the first pulse at cycle T → pulses at T, T+10, T+15, T+20, … while held; none after release.
- Hold `btn_dn`, assert reset for 1 cycle mid-hold → `pulse` 0 and levels cleared; one new pulse with `cnt_up` = 0 comes 7 cycles after reset release.

Source files
------------

// File: rtl/btn_step_pulse_gen.sv
// Button front end: synchronizes and debounces up/down buttons and emits one step pulse per accepted press.
// Define STEP_AUTOREPEAT_EN to compile in the hold-to-repeat FSM and timer.
module btn_step_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_dn,
    output logic pulse,
    output logic cnt_up,
    output logic up_level,
    output logic dn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("btn_step_pulse_gen: DEBOUNCE_CYCLES must be >= 2, HOLD/REPEAT_CYCLES >= 1");
    end

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_lvl;
    logic [1:0]    r_lvl_q;
    logic [CW-1:0] r_db_cnt [2];
    logic          r_pulse;
    logic          r_cnt_up;
    logic [1:0]    w_rise;
    logic          w_acc_up;
    logic          w_acc_dn;
    logic          w_accept;
    logic          w_rpt_fire;

    assign w_raw = {btn_dn, btn_up};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
            r_lvl_q <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_lvl_q <= r_lvl;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_lvl[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press counts only if the other button is released after this edge, which
    // also rejects both buttons rising together.
    assign w_rise   = r_lvl & ~r_lvl_q;
    assign w_acc_up = w_rise[0] & ~r_lvl[1];
    assign w_acc_dn = w_rise[1] & ~r_lvl[0];
    assign w_accept = w_acc_up | w_acc_dn;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pulse  <= 1'b0;
            r_cnt_up <= 1'b1;
        end else begin
            r_pulse <= w_accept | w_rpt_fire;
            if (w_accept) begin
                r_cnt_up <= w_acc_up;
            end
        end
    end

`ifdef STEP_AUTOREPEAT_EN
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] RPT_LAST  = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic          w_tmr_clr;
    logic          w_held;
    logic          w_other;

    // The latched direction identifies which button is being held.
    assign w_held  = r_cnt_up ? r_lvl[0] : r_lvl[1];
    assign w_other = r_cnt_up ? r_lvl[1] : r_lvl[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tmr_clr || r_state == ST_IDLE) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_clr   = 1'b0;
        w_rpt_fire  = 1'b0;
        if (w_accept) begin
            w_state_nxt = ST_HOLD;
            w_tmr_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_HOLD: begin
                    if (!w_held || w_other) begin
                        w_state_nxt = ST_IDLE;
                        w_tmr_clr   = 1'b1;
                    end else if (r_timer == HOLD_LAST) begin
                        w_state_nxt = ST_REPEAT;
                        w_tmr_clr   = 1'b1;
                        w_rpt_fire  = 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!w_held || w_other) begin
                        w_state_nxt = ST_IDLE;
                        w_tmr_clr   = 1'b1;
                    end else if (r_timer == RPT_LAST) begin
                        w_tmr_clr   = 1'b1;
                        w_rpt_fire  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_tmr_clr   = 1'b1;
                end
            endcase
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    assign pulse    = r_pulse;
    assign cnt_up   = r_cnt_up;
    assign up_level = r_lvl[0];
    assign dn_level = r_lvl[1];

endmodule

// File: tb/tb_btn_step_pulse_gen.sv
// Self-checking bench for btn_step_pulse_gen with DEBOUNCE=4, HOLD=10, REPEAT=5.
// A window-based behavioural model is compared every cycle; directed scenarios add literal timing checks.
module tb_btn_step_pulse_gen;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 5;

    logic clk = 1'b0;
    logic reset;
    logic btn_up;
    logic btn_dn;
    logic pulse;
    logic cnt_up;
    logic up_level;
    logic dn_level;

    always #5 clk = ~clk;

    btn_step_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .pulse   (pulse),
        .cnt_up  (cnt_up),
        .up_level(up_level),
        .dn_level(dn_level)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int ptimes[$];

    // Model state: a level flips once the last D synchronized samples all disagree with it.
    logic [1:0]   m_raw1, m_raw2, m_lvl, m_s, m_new, m_rise;
    logic [D-1:0] m_win [2];
    logic         m_pulse, m_cnt_up, m_acc_pend, m_acc_dir, m_rep_on, m_held, m_other;
    int           m_t0, m_k;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        cyc++;
        if (!reset) begin
            m_raw1 = '0; m_raw2 = '0; m_lvl = '0;
            m_win[0] = '0; m_win[1] = '0;
            m_pulse = 1'b0; m_cnt_up = 1'b1;
            m_acc_pend = 1'b0; m_acc_dir = 1'b0;
            m_rep_on = 1'b0; m_t0 = 0;
        end else begin
            m_pulse = 1'b0;
            if (m_acc_pend) begin
                m_pulse  = 1'b1;
                m_cnt_up = m_acc_dir;
                m_rep_on = 1'b1;
                m_t0     = cyc;
            end
`ifdef STEP_AUTOREPEAT_EN
            else if (m_rep_on) begin
                m_held  = m_cnt_up ? m_lvl[0] : m_lvl[1];
                m_other = m_cnt_up ? m_lvl[1] : m_lvl[0];
                if (!m_held || m_other) begin
                    m_rep_on = 1'b0;
                end else begin
                    m_k = cyc - m_t0;
                    if (m_k == H || (m_k > H && (m_k - H) % R == 0)) m_pulse = 1'b1;
                end
            end
`endif
            m_s    = m_raw2;
            m_raw2 = m_raw1;
            m_raw1 = {btn_dn, btn_up};
            for (int b = 0; b < 2; b++) begin
                m_win[b] = {m_win[b][D-2:0], m_s[b]};
                m_new[b] = (m_win[b] == {D{~m_lvl[b]}}) ? ~m_lvl[b] : m_lvl[b];
            end
            m_rise     = m_new & ~m_lvl;
            m_acc_pend = (m_rise[0] & ~m_new[1]) | (m_rise[1] & ~m_new[0]);
            m_acc_dir  = m_rise[0];
            m_lvl      = m_new;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("pulse", int'(pulse), int'(m_pulse));
        chk("cnt_up", int'(cnt_up), int'(m_cnt_up));
        chk("up_level", int'(up_level), int'(m_lvl[0]));
        chk("dn_level", int'(dn_level), int'(m_lvl[1]));
        if (pulse) ptimes.push_back(cyc);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    int t0, tl, tr, tp, base;
    int exp_t[$];

    initial begin
        reset  = 1'b0;
        btn_up = 1'b0;
        btn_dn = 1'b0;

        // Reset held for three edges, then idle
        repeat (3) tick();
        chk("rst_pulse", int'(pulse), 0);
        chk("rst_cnt_up", int'(cnt_up), 1);
        chk("rst_up_level", int'(up_level), 0);
        chk("rst_dn_level", int'(dn_level), 0);
        reset = 1'b1;
        base = ptimes.size();
        repeat (50) tick();
        chk("idle_pulses", ptimes.size() - base, 0);

        // Single up press and hold
        t0 = cyc; base = ptimes.size();
        btn_up = 1'b1;
        wait_to(t0 + 5);
        chk("up_lvl_before", int'(up_level), 0);
        tick();
        chk("up_lvl_rise", int'(up_level), 1);
        chk("up_no_early_pulse", int'(pulse), 0);
        tick();
        chk("up_pulse", int'(pulse), 1);
        chk("up_dir", int'(cnt_up), 1);
        tick();
        chk("up_pulse_1cyc", int'(pulse), 0);
        wait_to(t0 + 40);
`ifdef STEP_AUTOREPEAT_EN
        chk("up_hold_pulses", ptimes.size() - base, 6);
`else
        chk("up_hold_pulses", ptimes.size() - base, 1);
`endif
        btn_up = 1'b0;
        repeat (20) tick();

        // Bouncing down press
        t0 = cyc; base = ptimes.size();
        btn_dn = 1'b1; tick(); tick();
        btn_dn = 1'b0; tick(); tick();
        btn_dn = 1'b1; tl = cyc;
        wait_to(tl + 6);
        chk("bounce_no_early", int'(pulse), 0);
        tick();
        chk("bounce_pulse", int'(pulse), 1);
        chk("bounce_dir", int'(cnt_up), 0);
        wait_to(tl + 15);
        chk("bounce_pulses", ptimes.size() - base, 1);
        btn_dn = 1'b0;
        repeat (20) tick();

        // Both buttons together
        t0 = cyc; base = ptimes.size();
        btn_up = 1'b1; btn_dn = 1'b1;
        wait_to(t0 + 6);
        chk("both_up_lvl", int'(up_level), 1);
        chk("both_dn_lvl", int'(dn_level), 1);
        wait_to(t0 + 20);
        chk("both_pulses", ptimes.size() - base, 0);
        chk("both_dir_held", int'(cnt_up), 0);
        btn_up = 1'b0; btn_dn = 1'b0;
        repeat (20) tick();

        // Glitch shorter than the debounce window
        base = ptimes.size();
        btn_up = 1'b1; repeat (3) tick();
        btn_up = 1'b0; repeat (20) tick();
        chk("glitch_pulses", ptimes.size() - base, 0);
        chk("glitch_level", int'(up_level), 0);

        // Long up hold: repeat schedule when enabled
        t0 = cyc; base = ptimes.size();
        tp = t0 + 7;
        btn_up = 1'b1;
        wait_to(tp + 40);
        btn_up = 1'b0;
        wait_to(tp + 60);
        exp_t = {tp};
`ifdef STEP_AUTOREPEAT_EN
        for (int k = H; k <= 45; k += R) exp_t.push_back(tp + k);
`endif
        chk("hold_count", ptimes.size() - base, exp_t.size());
        foreach (exp_t[i]) begin
            if (base + i < ptimes.size()) chk("hold_time", ptimes[base + i], exp_t[i]);
        end
        repeat (10) tick();

        // Reset during a down hold
        t0 = cyc;
        btn_dn = 1'b1;
        wait_to(t0 + 15);
        chk("pre_rst_dn_lvl", int'(dn_level), 1);
        reset = 1'b0;
        tick();
        chk("mid_rst_pulse", int'(pulse), 0);
        chk("mid_rst_dn_lvl", int'(dn_level), 0);
        chk("mid_rst_up_lvl", int'(up_level), 0);
        chk("mid_rst_dir", int'(cnt_up), 1);
        reset = 1'b1;
        tr = cyc; base = ptimes.size();
        wait_to(tr + 6);
        chk("post_rst_no_early", int'(pulse), 0);
        tick();
        chk("post_rst_pulse", int'(pulse), 1);
        chk("post_rst_dir", int'(cnt_up), 0);
        tick();
        chk("post_rst_1cyc", int'(pulse), 0);
        wait_to(tr + 12);
        chk("post_rst_count", ptimes.size() - base, 1);
        btn_dn = 1'b0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
